// File: rtl/rv32i_multicycle_cu.sv
// Multi-cycle control unit for the RV32I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a single shared variable-latency
// memory port, traps on illegal opcodes and memory timeouts, and counts
// retired instructions. Strobes depend on mem_ready in the same cycle, so
// they are decoded combinationally from the registered state.
module rv32i_multicycle_cu #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWr,
  output logic             IRWr,
  output logic             PCWr,
  output logic             RegWr,
  output logic [3:0]       ALUSel,
  output logic             ASel,
  output logic [1:0]       BSel,
  output logic [2:0]       PCSel,
  output logic [2:0]       ImmSel,
  output logic             WBSel,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b111
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_CNT = TIMEOUT_W'(TIMEOUT);

  state_t               state_reg;
  logic [TIMEOUT_W-1:0] wait_cnt_reg;
  logic [TIMEOUT_W-1:0] wait_cnt_inc;
  logic                 trap_reg;
  logic [1:0]           trap_cause_reg;
  logic [CNT_W-1:0]     instret_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       is_legal;
  logic       timeout_hit;
  logic       unused_instr_bits;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7_5 = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_legal  = (opcode == OP_LUI)  || (opcode == OP_AUIPC) ||
                     (opcode == OP_IMM)  || (opcode == OP_REG)   ||
                     (opcode == OP_JAL)  || (opcode == OP_JALR)  ||
                     is_branch || is_load || is_store;

  // A waiting cycle whose count would reach TIMEOUT traps; mem_ready wins.
  assign wait_cnt_inc = wait_cnt_reg + TIMEOUT_W'(1);
  assign timeout_hit  = (TIMEOUT != 0) && mem_req && !mem_ready &&
                        (wait_cnt_inc == TIMEOUT_CNT);

  assign state      = state_reg;
  assign trap       = trap_reg;
  assign trap_cause = trap_cause_reg;
  assign instret    = instret_reg;

  // FSM sequencing, memory wait counter, trap capture and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_FETCH;
      wait_cnt_reg   <= '0;
      trap_reg       <= 1'b0;
      trap_cause_reg <= 2'b00;
      instret_reg    <= '0;
    end else begin
      if (mem_req && !mem_ready && !timeout_hit) begin
        wait_cnt_reg <= wait_cnt_inc;
      end else begin
        wait_cnt_reg <= '0;
      end

      if (PCWr) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end

      case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            state_reg <= S_DECODE;
          end else if (timeout_hit) begin
            state_reg      <= S_TRAP;
            trap_reg       <= 1'b1;
            trap_cause_reg <= 2'b10;
          end
        end
        S_DECODE: begin
          if (is_legal) begin
            state_reg <= S_EXEC;
          end else begin
            state_reg      <= S_TRAP;
            trap_reg       <= 1'b1;
            trap_cause_reg <= 2'b01;
          end
        end
        S_EXEC: begin
          state_reg <= (is_load || is_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            state_reg <= is_load ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            state_reg      <= S_TRAP;
            trap_reg       <= 1'b1;
            trap_cause_reg <= 2'b10;
          end
        end
        S_WB: begin
          state_reg <= S_FETCH;
        end
        S_TRAP: begin
          state_reg <= S_TRAP;
        end
        default: begin
          state_reg <= S_FETCH;
        end
      endcase
    end
  end

  // Memory and commit strobes; all held low while reset is asserted.
  always_comb begin
    mem_req = 1'b0;
    MemWr   = 1'b0;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    RegWr   = 1'b0;
    IorD    = (state_reg == S_MEM);
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          mem_req = 1'b1;
          IRWr    = mem_ready;
        end
        S_MEM: begin
          mem_req = 1'b1;
          MemWr   = is_store;
          PCWr    = is_store && mem_ready;
        end
        S_WB: begin
          PCWr  = 1'b1;
          RegWr = !is_branch;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  // Datapath selects from the IR; FETCH and TRAP drive the default row.
  always_comb begin
    ALUSel = 4'b0000;
    ASel   = 1'b1;
    BSel   = 2'b00;
    PCSel  = 3'b111;
    ImmSel = 3'b000;
    WBSel  = 1'b0;
    if (state_reg != S_FETCH && state_reg != S_TRAP) begin
      case (opcode)
        OP_LUI: begin
          ALUSel = 4'b1111;
          BSel   = 2'b01;
          ImmSel = 3'b001;
        end
        OP_AUIPC: begin
          ASel   = 1'b0;
          BSel   = 2'b01;
          ImmSel = 3'b001;
        end
        OP_IMM: begin
          ALUSel = {(funct3 == 3'b101) && funct7_5, funct3};
          BSel   = 2'b01;
        end
        OP_REG: begin
          ALUSel = {funct7_5, funct3};
        end
        OP_JAL: begin
          ASel   = 1'b0;
          BSel   = 2'b10;
          PCSel  = 3'b011;
          ImmSel = 3'b100;
        end
        OP_JALR: begin
          ASel  = 1'b0;
          BSel  = 2'b10;
          PCSel = 3'b110;
        end
        OP_BRANCH: begin
          ALUSel = {funct3[2:1] == 2'b00, 1'b0, funct3[2:1]};
          PCSel  = funct3;
          ImmSel = 3'b011;
        end
        OP_LOAD: begin
          BSel  = 2'b01;
          WBSel = 1'b1;
        end
        OP_STORE: begin
          BSel   = 2'b01;
          ImmSel = 3'b010;
        end
        default: begin
          ALUSel = 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: doc/rv32i_multicycle_cu.md
Name: rv32i_multicycle_cu

Overview:
Multi-cycle control unit for the RV32I core. It replaces the single-cycle combinational decoder with an FSM that sequences fetch, decode, execute, memory and writeback over several clocks. The FSM handshakes with a single shared instruction/data memory port that has variable latency. It also detects illegal opcodes and memory timeouts, and keeps a retired-instruction counter. It sits between the instruction register/datapath and the unified memory interface.

Parameters:
TIMEOUT, 255, maximum cycles mem_req may stay high without mem_ready before trapping; 0 disables the timeout.
TIMEOUT_W, 8, width of the wait counter; must satisfy TIMEOUT < 2**TIMEOUT_W.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
instr  in  32  current IR contents; opcode=[6:0], funct3=[14:12], funct7=[31:25]
mem_ready  in  1  memory has completed the current request this cycle
mem_req  out  1  memory request valid
IorD  out  1  0 = instruction address (PC), 1 = data address (ALU result)
MemWr  out  1  request is a write; only ever high with mem_req
IRWr  out  1  latch instruction from memory into IR
PCWr  out  1  commit next PC (per PCSel); marks instruction retire
RegWr  out  1  register file write strobe
ALUSel  out  4  ALU op
ASel  out  1  0 = pc, 1 = rs1
BSel  out  2  00 = rs2, 01 = imm, 10 = const 4
PCSel  out  3  branch funct3; 011 = jal, 110 = jalr, 111 = pc+4
ImmSel  out  3  000 = I, 001 = U, 010 = S, 011 = B, 100 = J
WBSel  out  1  0 = ALU, 1 = memory
state  out  3  FSM state, for debug
trap  out  1  sticky trap flag
trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst=1 at a rising edge sets state=FETCH, wait counter=0, trap=0, trap_cause=00, instret=0.
- While rst=1, every strobe output (mem_req, MemWr, IRWr, PCWr, RegWr) is forced to 0.
- Reset mid-operation aborts any outstanding request; no write or commit occurs in that cycle.
- States and encodings: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=111.
- FETCH: mem_req=1, IorD=0. When mem_ready=1, IRWr=1 in the same cycle, then go to DECODE.
- DECODE: 1 cycle. Legal opcodes are lui, auipc, OP-IMM, OP, jal, jalr, branch, load, store.
  - Legal opcode: go to EXEC.
  - Any other opcode: go to TRAP with cause 01.
- EXEC: 1 cycle. Load/store go to MEM; all other opcodes go to WB.
- MEM: mem_req=1, IorD=1, MemWr=1 for store only. Wait for mem_ready.
  - Load: go to WB.
  - Store: PCWr=1 in the mem_ready cycle, then go to FETCH.
- WB: 1 cycle. PCWr=1. RegWr=1 unless the opcode is branch. Then go to FETCH.
- TRAP: all strobes 0. Stay in TRAP until rst. trap=1 and trap_cause hold their values.
- Datapath selects are combinational from instr in DECODE, EXEC, MEM and WB. In FETCH they are don't-care but must be driven deterministic (drive the default row).
  - ALUSel: add for auipc, jal, jalr, load, store; 1111 (pass B) for lui.
  - ALUSel, OP: {funct7[5], funct3}.
  - ALUSel, OP-IMM: {funct3==101 & funct7[5], funct3}.
  - ALUSel, branch: {funct3[2:1]==00, 0, funct3[2:1]}.
  - ASel=pc for auipc, jal, jalr; rs1 otherwise.
  - BSel=4 for jal and jalr; imm for lui, auipc, OP-IMM, load, store; rs2 otherwise.
  - PCSel=funct3 for branches; jal/jalr codes for jal/jalr; 111 otherwise.
  - WBSel=1 only for load.
  - ImmSel per instruction format.
- Wait counter: increments each cycle that mem_req=1 and mem_ready=0; clears when mem_ready=1 or on a state change.
  - If TIMEOUT≠0 and the counter equals TIMEOUT while mem_ready=0: go to TRAP with cause 10.
  - mem_ready arriving in the same cycle the count reaches TIMEOUT takes priority (no trap).
- instret: increments by 1 on each cycle PCWr=1 and wraps modulo 2**CNT_W. It never increments in TRAP.
- Latency with mem_ready tied high: ALU, jump, branch, lui, auipc = 4 cycles; store = 4 cycles; load = 5 cycles. Each memory wait cycle adds 1.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready=1 -> states 000,001,010,100. IRWr in cycle 1, RegWr and PCWr in cycle 4 with ALUSel=0000, BSel=01, ASel=1. instret=1.
- lw (opcode 0000011) with 3 wait cycles on the data access -> MEM lasts 4 cycles with IorD=1, MemWr=0. Then WB has WBSel=1, RegWr=1. Total 8 cycles.
- sw (0100011), mem_ready=1 -> MEM has mem_req=1, MemWr=1, PCWr=1 and RegWr=0. 4 cycles total; next state FETCH.
- beq (funct3 000) -> WB has PCWr=1, RegWr=0, PCSel=000, ALUSel=1000. Then bltu (110) -> ALUSel=0011, PCSel=110.
- instr=0x0000007F, then mem_ready toggled -> TRAP after DECODE with trap=1, cause=01. No further strobes; instret unchanged. rst returns state to FETCH with trap=0.
- TIMEOUT=4, mem_ready held 0 in FETCH -> trap with cause 10 after 4 waiting cycles. Repeat with mem_ready=1 on the 4th cycle -> no trap. Assert rst mid-MEM -> no PCWr/RegWr; state=FETCH next cycle.
